// File: rtl/alu_multicycle.sv
// Clocked ALU: single-cycle ops complete at the Start edge (Done next cycle); LSL/LSR take n = min(B, W) edges.
// No queueing: Start is only honoured in IDLE, so a Start seen while Busy is dropped.
module alu_multicycle #(
  parameter int W   = 8,
  parameter int OPS = 3
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  input  logic [W-1:0]   InputA,
  input  logic [W-1:0]   InputB,
  input  logic [OPS-1:0] OP,
  input  logic           SC_in,
  output logic [W-1:0]   Out,
  output logic           Zero,
  output logic           Parity,
  output logic           Odd,
  output logic           Carry,
  output logic           Busy,
  output logic           Done
);
  localparam int CW = $clog2(W) + 1;

  localparam logic [0:0] STATE_IDLE  = 1'b0;
  localparam logic [0:0] STATE_SHIFT = 1'b1;

  localparam logic [OPS-1:0] OP_ADD = OPS'(0);
  localparam logic [OPS-1:0] OP_LSL = OPS'(1);
  localparam logic [OPS-1:0] OP_LSR = OPS'(2);
  localparam logic [OPS-1:0] OP_XOR = OPS'(3);
  localparam logic [OPS-1:0] OP_SNE = OPS'(4);
  localparam logic [OPS-1:0] OP_SEQ = OPS'(5);
  localparam logic [OPS-1:0] OP_MSK = OPS'(6);
  localparam logic [OPS-1:0] OP_ADC = OPS'(7);

  localparam logic [W-1:0]  ONE_W = W'(1);
  localparam logic [W-1:0]  W_LIM = W'(W);
  localparam logic [CW-1:0] W_CNT = CW'(W);

  logic [0:0]    state;
  logic [W-1:0]  work;
  logic          fill;
  logic          dir_left;
  logic [CW-1:0] cnt;

  logic [W:0]    sum;
  logic [W-1:0]  res;
  logic          res_c;
  logic [CW-1:0] n_sat;
  logic          is_shift;
  logic [W-1:0]  shifted;
  logic          out_bit;

  // ADC folds the carry-in into the same W+1 bit adder as ADD.
  always_comb begin
    sum = {1'b0, InputA} + {1'b0, InputB} + ((OP == OP_ADC) ? (W+1)'(SC_in) : '0);
  end

  always_comb begin
    n_sat    = (InputB >= W_LIM) ? W_CNT : InputB[CW-1:0];
    is_shift = (OP == OP_LSL) || (OP == OP_LSR);
  end

  // Shift results here only cover n == 0, where Out passes A through.
  always_comb begin
    res   = InputA;
    res_c = 1'b0;
    case (OP)
      OP_ADD, OP_ADC: begin
        res   = sum[W-1:0];
        res_c = sum[W];
      end
      OP_LSL, OP_LSR: res = InputA;
      OP_XOR:         res = InputA ^ InputB;
      OP_SNE:         res = (InputA != InputB) ? ONE_W : '0;
      OP_SEQ:         res = (InputA == InputB) ? ONE_W : '0;
      OP_MSK:         res = InputA ^ (ONE_W << InputB);
      default:        res = '0;
    endcase
  end

  always_comb begin
    shifted = dir_left ? {work[W-2:0], fill} : {fill, work[W-1:1]};
    out_bit = dir_left ? work[W-1] : work[0];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= STATE_IDLE;
      work     <= '0;
      fill     <= 1'b0;
      dir_left <= 1'b0;
      cnt      <= '0;
      Out      <= '0;
      Carry    <= 1'b0;
      Done     <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        STATE_IDLE: begin
          if (Start) begin
            if (is_shift && (n_sat != '0)) begin
              work     <= InputA;
              fill     <= SC_in;
              dir_left <= (OP == OP_LSL);
              cnt      <= n_sat;
              state    <= STATE_SHIFT;
            end else begin
              Out   <= res;
              Carry <= res_c;
              Done  <= 1'b1;
            end
          end
        end
        default: begin
          work <= shifted;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            Out   <= shifted;
            Carry <= out_bit;
            Done  <= 1'b1;
            state <= STATE_IDLE;
          end
        end
      endcase
    end
  end

  assign Busy   = (state == STATE_SHIFT);
  assign Zero   = ~|Out;
  assign Parity = ^Out;
  assign Odd    = Out[0];

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle at W=8 and W=16; expected values are hand-computed.
module tb_alu_multicycle;
  logic        Clk;
  logic        Reset;

  logic        Start8, SC8;
  logic [7:0]  A8, B8;
  logic [2:0]  OP8;
  logic [7:0]  Out8;
  logic        Zero8, Parity8, Odd8, Carry8, Busy8, Done8;

  logic        Start16, SC16;
  logic [15:0] A16, B16;
  logic [2:0]  OP16;
  logic [15:0] Out16;
  logic        Zero16, Parity16, Odd16, Carry16, Busy16, Done16;

  int errors = 0;
  int checks = 0;

  alu_multicycle #(.W(8), .OPS(3)) dut8 (
    .Clk(Clk), .Reset(Reset), .Start(Start8), .InputA(A8), .InputB(B8), .OP(OP8),
    .SC_in(SC8), .Out(Out8), .Zero(Zero8), .Parity(Parity8), .Odd(Odd8),
    .Carry(Carry8), .Busy(Busy8), .Done(Done8)
  );

  alu_multicycle #(.W(16), .OPS(3)) dut16 (
    .Clk(Clk), .Reset(Reset), .Start(Start16), .InputA(A16), .InputB(B16), .OP(OP16),
    .SC_in(SC16), .Out(Out16), .Zero(Zero16), .Parity(Parity16), .Odd(Odd16),
    .Carry(Carry16), .Busy(Busy16), .Done(Done16)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Inputs change on the falling edge; after issue8 returns, the Start edge has passed.
  task automatic issue8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic sc);
    OP8 = op; A8 = a; B8 = b; SC8 = sc; Start8 = 1'b1;
    @(negedge Clk);
    Start8 = 1'b0;
  endtask

  task automatic issue16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic sc);
    OP16 = op; A16 = a; B16 = b; SC16 = sc; Start16 = 1'b1;
    @(negedge Clk);
    Start16 = 1'b0;
  endtask

  // lat = rising edges after the Start edge until Done is seen; busy = cycles with Busy high.
  task automatic wait8(input int first, output int lat, output int busy);
    lat = first; busy = 0;
    while (Done8 !== 1'b1 && lat < 60) begin
      if (Busy8 === 1'b1) busy++;
      @(negedge Clk);
      lat++;
    end
  endtask

  task automatic wait16(output int lat);
    lat = 0;
    while (Done16 !== 1'b1 && lat < 60) begin
      @(negedge Clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    checks++; if (Out8 !== 8'h00) begin errors++; $display("FAIL reset_out: got %h expected 00", Out8); end
    checks++; if ({Zero8, Parity8, Odd8} !== 3'b100) begin errors++; $display("FAIL reset_flags: got %b expected 100", {Zero8, Parity8, Odd8}); end
    checks++; if ({Carry8, Busy8, Done8} !== 3'b000) begin errors++; $display("FAIL reset_ctl: got %b expected 000", {Carry8, Busy8, Done8}); end
    OP8 = 3'd0; A8 = 8'd1; B8 = 8'd1; SC8 = 1'b0; Start8 = 1'b1;
    @(negedge Clk);
    checks++; if (Done8 !== 1'b0 || Out8 !== 8'h00) begin errors++; $display("FAIL reset_beats_start: got done=%b out=%h expected 0/00", Done8, Out8); end
    Start8 = 1'b0; Reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_add;
    int lat, busy;
    issue8(3'd0, 8'd200, 8'd100, 1'b0);
    wait8(0, lat, busy);
    checks++; if (lat !== 0 || busy !== 0) begin errors++; $display("FAIL add_latency: got lat=%0d busy=%0d expected 0/0", lat, busy); end
    checks++; if (Out8 !== 8'd44 || Carry8 !== 1'b1) begin errors++; $display("FAIL add_result: got %0d c=%b expected 44 c=1", Out8, Carry8); end
    checks++; if (Parity8 !== 1'b1) begin errors++; $display("FAIL add_parity: got %b expected 1", Parity8); end
    @(negedge Clk);
    checks++; if (Done8 !== 1'b0 || Out8 !== 8'd44) begin errors++; $display("FAIL add_done_pulse: got done=%b out=%0d expected 0/44", Done8, Out8); end
    issue8(3'd7, 8'd200, 8'd100, 1'b1);
    checks++; if (Done8 !== 1'b1 || Out8 !== 8'd45 || Carry8 !== 1'b1) begin errors++; $display("FAIL adc_result: got done=%b %0d c=%b expected 1 45 c=1", Done8, Out8, Carry8); end
    @(negedge Clk);
  endtask

  task automatic test_shift;
    int lat, busy;
    issue8(3'd1, 8'h81, 8'd3, 1'b0);
    wait8(0, lat, busy);
    checks++; if (lat !== 3 || busy !== 3) begin errors++; $display("FAIL lsl3_timing: got lat=%0d busy=%0d expected 3/3", lat, busy); end
    checks++; if (Out8 !== 8'h08 || Carry8 !== 1'b0) begin errors++; $display("FAIL lsl3_result: got %h c=%b expected 08 c=0", Out8, Carry8); end
    @(negedge Clk);
    issue8(3'd2, 8'h01, 8'd1, 1'b1);
    wait8(0, lat, busy);
    checks++; if (lat !== 1 || busy !== 1) begin errors++; $display("FAIL lsr1_timing: got lat=%0d busy=%0d expected 1/1", lat, busy); end
    checks++; if (Out8 !== 8'h80 || Carry8 !== 1'b1) begin errors++; $display("FAIL lsr1_result: got %h c=%b expected 80 c=1", Out8, Carry8); end
    @(negedge Clk);
    issue8(3'd1, 8'hFF, 8'd20, 1'b0);
    wait8(0, lat, busy);
    checks++; if (lat !== 8 || busy !== 8) begin errors++; $display("FAIL lsl_sat_timing: got lat=%0d busy=%0d expected 8/8", lat, busy); end
    checks++; if (Out8 !== 8'h00 || Zero8 !== 1'b1 || Carry8 !== 1'b1) begin errors++; $display("FAIL lsl_sat_result: got %h z=%b c=%b expected 00 z=1 c=1", Out8, Zero8, Carry8); end
    @(negedge Clk);
    issue8(3'd1, 8'h5A, 8'd0, 1'b1);
    checks++; if (Done8 !== 1'b1 || Busy8 !== 1'b0 || Out8 !== 8'h5A || Carry8 !== 1'b0) begin errors++; $display("FAIL lsl0_result: got done=%b busy=%b %h c=%b expected 1 0 5a c=0", Done8, Busy8, Out8, Carry8); end
    @(negedge Clk);
  endtask

  task automatic test_compare_mask;
    issue8(3'd5, 8'd5, 8'd5, 1'b0);
    checks++; if (Out8 !== 8'd1 || Odd8 !== 1'b1 || Carry8 !== 1'b0) begin errors++; $display("FAIL seq_eq: got %0d odd=%b c=%b expected 1 odd=1 c=0", Out8, Odd8, Carry8); end
    issue8(3'd4, 8'd5, 8'd5, 1'b0);
    checks++; if (Out8 !== 8'd0 || Zero8 !== 1'b1) begin errors++; $display("FAIL sne_eq: got %0d z=%b expected 0 z=1", Out8, Zero8); end
    issue8(3'd4, 8'd5, 8'd6, 1'b0);
    checks++; if (Out8 !== 8'd1) begin errors++; $display("FAIL sne_ne: got %0d expected 1", Out8); end
    issue8(3'd6, 8'h00, 8'd6, 1'b0);
    checks++; if (Out8 !== 8'h40) begin errors++; $display("FAIL msk_bit6: got %h expected 40", Out8); end
    issue8(3'd6, 8'h33, 8'd9, 1'b0);
    checks++; if (Out8 !== 8'h33) begin errors++; $display("FAIL msk_oob: got %h expected 33", Out8); end
    issue8(3'd3, 8'hF0, 8'h3C, 1'b0);
    checks++; if (Out8 !== 8'hCC || Carry8 !== 1'b0) begin errors++; $display("FAIL xor: got %h c=%b expected cc c=0", Out8, Carry8); end
    @(negedge Clk);
  endtask

  task automatic test_back_to_back;
    int lat, busy;
    issue8(3'd1, 8'h03, 8'd4, 1'b1);
    @(negedge Clk);
    OP8 = 3'd0; A8 = 8'hAA; B8 = 8'd1; Start8 = 1'b1;
    @(negedge Clk);
    Start8 = 1'b0;
    wait8(2, lat, busy);
    checks++; if (lat !== 4) begin errors++; $display("FAIL busy_ignore_lat: got %0d expected 4", lat); end
    checks++; if (Out8 !== 8'h3F || Carry8 !== 1'b0) begin errors++; $display("FAIL busy_ignore_result: got %h c=%b expected 3f c=0", Out8, Carry8); end
    issue8(3'd0, 8'd1, 8'd2, 1'b0);
    checks++; if (Done8 !== 1'b1 || Out8 !== 8'd3) begin errors++; $display("FAIL b2b_accept: got done=%b %0d expected 1 3", Done8, Out8); end
    @(negedge Clk);
  endtask

  task automatic test_reset_mid_shift;
    int dones;
    issue8(3'd1, 8'h81, 8'd4, 1'b0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    checks++; if ({Busy8, Done8} !== 2'b00 || Out8 !== 8'h00 || Zero8 !== 1'b1) begin errors++; $display("FAIL reset_abort: got busy=%b done=%b %h z=%b expected 0 0 00 1", Busy8, Done8, Out8, Zero8); end
    dones = 0;
    repeat (8) begin
      @(negedge Clk);
      if (Done8 === 1'b1) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL reset_no_done: got %0d expected 0", dones); end
  endtask

  task automatic test_w16;
    int lat;
    issue16(3'd2, 16'h8000, 16'd15, 1'b0);
    wait16(lat);
    checks++; if (lat !== 15 || Out16 !== 16'h0001 || Carry16 !== 1'b0) begin errors++; $display("FAIL w16_lsr15: got lat=%0d %h c=%b expected 15 0001 c=0", lat, Out16, Carry16); end
    @(negedge Clk);
    issue16(3'd0, 16'hFFFF, 16'h0001, 1'b0);
    checks++; if (Done16 !== 1'b1 || Out16 !== 16'h0000 || Carry16 !== 1'b1 || Zero16 !== 1'b1) begin errors++; $display("FAIL w16_add: got done=%b %h c=%b z=%b expected 1 0000 1 1", Done16, Out16, Carry16, Zero16); end
    @(negedge Clk);
    issue16(3'd1, 16'h0001, 16'd40, 1'b0);
    wait16(lat);
    checks++; if (lat !== 16 || Out16 !== 16'h0000 || Carry16 !== 1'b1) begin errors++; $display("FAIL w16_lsl_sat: got lat=%0d %h c=%b expected 16 0000 c=1", lat, Out16, Carry16); end
    @(negedge Clk);
    issue16(3'd6, 16'h0000, 16'd12, 1'b0);
    checks++; if (Out16 !== 16'h1000 || Odd16 !== 1'b0 || Parity16 !== 1'b1) begin errors++; $display("FAIL w16_msk: got %h odd=%b par=%b expected 1000 0 1", Out16, Odd16, Parity16); end
    @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b1;
    Start8 = 1'b0; A8 = '0; B8 = '0; OP8 = '0; SC8 = 1'b0;
    Start16 = 1'b0; A16 = '0; B16 = '0; OP16 = '0; SC16 = 1'b0;
    test_reset;
    test_add;
    test_shift;
    test_compare_mask;
    test_back_to_back;
    test_reset_mid_shift;
    test_w16;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
